// File: rtl/uart_tx_pkg.sv
// Shared types and mux-select encoding for the UART transmit path.
// The TX output mux decodes the same SEL_* constants.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic [1:0] SEL_START = 2'b00;
   localparam logic [1:0] SEL_STOP  = 2'b01;
   localparam logic [1:0] SEL_DATA  = 2'b10;
   localparam logic [1:0] SEL_PAR   = 2'b11;

   function automatic logic [1:0] sel_of(input tx_state_e st);
      logic [1:0] sel;
      case (st)
         START:   sel = SEL_START;
         DATA:    sel = SEL_DATA;
         PARITY:  sel = SEL_PAR;
         STOP:    sel = SEL_STOP;
         default: sel = SEL_STOP;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte request and TX-mux control bundle between the transmit controller
// and its client and output mux.
interface uart_tx_ctrl_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] p_data;
   logic                  data_valid;
   logic                  par_en;
   logic                  par_typ;
   logic [1:0]            mux_sel;
   logic                  ser_data;
   logic                  par_bit;
   logic                  busy;

   modport master (
      output p_data, data_valid, par_en, par_typ,
      input  mux_sel, ser_data, par_bit, busy
   );

   modport slave (
      input  p_data, data_valid, par_en, par_typ,
      output mux_sel, ser_data, par_bit, busy
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// LSB-first shift register with bit counter; ser_done flags the last data bit.
module uart_tx_serializer #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] p_data,
   output logic                  ser_data,
   output logic                  ser_done
);
   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shift_r;
   logic [CNT_W-1:0]      cnt_r;

   // Load the byte on acceptance, then shift one bit per DATA cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r <= {DATA_WIDTH{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
      end else if (load) begin
         shift_r <= p_data;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (shift_en) begin
         shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
         cnt_r   <= cnt_r + CNT_W'(1);
      end else begin
         shift_r <= shift_r;
         cnt_r   <= cnt_r;
      end
   end

   assign ser_data = shift_r[0];
   assign ser_done = (cnt_r == CNT_LAST);
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences start/data/parity/stop and drives the TX mux.
// Define UART_TX_BACK2BACK_EN to accept a new byte during the STOP cycle.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_tx_ctrl_if.slave   bus
);
   tx_state_e state_r;
   tx_state_e next_state_s;
   logic      accept_s;
   logic      shift_en_s;
   logic      ser_done_s;
   logic      ser_data_s;
   logic      par_en_r;
   logic      par_bit_r;
   logic [1:0] mux_sel_r;
   logic      busy_r;

   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept_s),
      .shift_en (shift_en_s),
      .p_data   (bus.p_data),
      .ser_data (ser_data_s),
      .ser_done (ser_done_s)
   );

   // Next-state and datapath strobes.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      shift_en_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.data_valid) begin
               accept_s     = 1'b1;
               next_state_s = START;
            end else begin
               next_state_s = IDLE;
            end
         end
         START:  next_state_s = DATA;
         DATA: begin
            shift_en_s = 1'b1;
            if (ser_done_s) begin
               if (par_en_r) begin
                  next_state_s = PARITY;
               end else begin
                  next_state_s = STOP;
               end
            end else begin
               next_state_s = DATA;
            end
         end
         PARITY: next_state_s = STOP;
         STOP: begin
`ifdef UART_TX_BACK2BACK_EN
            if (bus.data_valid) begin
               accept_s     = 1'b1;
               next_state_s = START;
            end else begin
               next_state_s = IDLE;
            end
`else
            next_state_s = IDLE;
`endif
         end
         default: next_state_s = IDLE;
      endcase
   end

   // State plus outputs pre-decoded from the next state so they are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         mux_sel_r <= SEL_STOP;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         mux_sel_r <= sel_of(next_state_s);
         busy_r    <= (next_state_s != IDLE);
      end
   end

   // Frame attributes captured at acceptance and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_en_r  <= 1'b0;
         par_bit_r <= 1'b0;
      end else if (accept_s) begin
         par_en_r  <= bus.par_en;
         par_bit_r <= parity_of(bus.p_data, bus.par_typ);
      end else begin
         par_en_r  <= par_en_r;
         par_bit_r <= par_bit_r;
      end
   end

   assign bus.mux_sel  = mux_sel_r;
   assign bus.busy     = busy_r;
   assign bus.ser_data = ser_data_s;
   assign bus.par_bit  = par_bit_r;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: frame-level reference model plus
// directed and randomized byte requests.
module tb_uart_tx_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] sel;
      logic       ser;
      logic       chk_ser;
   } exp_t;

   exp_t q[$];
   logic exp_par = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Expected line activity for one frame: start, 8 data bits LSB first, optional parity, stop.
   function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
      exp_t e;
      e = '{sel: 2'b00, ser: 1'b0, chk_ser: 1'b0};
      q.push_back(e);
      for (int i = 0; i < 8; i++) begin
         e = '{sel: 2'b10, ser: d[i], chk_ser: 1'b1};
         q.push_back(e);
      end
      if (pe) begin
         e = '{sel: 2'b11, ser: 1'b0, chk_ser: 1'b0};
         q.push_back(e);
      end
      e = '{sel: 2'b01, ser: 1'b0, chk_ser: 1'b0};
      q.push_back(e);
      exp_par = 1'(($countones(d) % 2) ^ int'(pt));
   endfunction

   // Reference model: one queue entry consumed per bit period.
   always @(posedge clk or negedge rst_n) begin
      bit acc;
      if (!rst_n) begin
         q.delete();
         exp_par = 1'b0;
      end else begin
`ifdef UART_TX_BACK2BACK_EN
         acc = bus.data_valid && (q.size() <= 1);
`else
         acc = bus.data_valid && (q.size() == 0);
`endif
         if (q.size() > 0) void'(q.pop_front());
         if (acc) push_frame(bus.p_data, bus.par_en, bus.par_typ);
      end
   end

   // Compare DUT against the model in the middle of each bit period.
   always @(negedge clk) begin
      if (rst_n) begin
         if (q.size() > 0) begin
            check_val("mux_sel", 32'(bus.mux_sel), 32'(q[0].sel));
            check_val("busy", 32'(bus.busy), 32'd1);
            if (q[0].chk_ser) check_val("ser_data", 32'(bus.ser_data), 32'(q[0].ser));
         end else begin
            check_val("mux_sel_idle", 32'(bus.mux_sel), 32'(2'b01));
            check_val("busy_idle", 32'(bus.busy), 32'd0);
         end
         check_val("par_bit", 32'(bus.par_bit), 32'(exp_par));
      end
   end

   // Request a frame, scramble inputs while it runs, optionally pulse data_valid mid-DATA.
   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int pulse_at);
      int cnt;
      @(negedge clk);
      bus.p_data = d;
      bus.par_en = pe;
      bus.par_typ = pt;
      bus.data_valid = 1'b1;
      @(negedge clk);
      cnt = 0;
      while (bus.busy && cnt < 40) begin
         cnt++;
         bus.data_valid = (cnt == pulse_at);
         bus.p_data = (cnt == pulse_at) ? 8'h3C : 8'($urandom);
         bus.par_en = 1'($urandom);
         bus.par_typ = 1'($urandom);
         @(negedge clk);
      end
      bus.data_valid = 1'b0;
      check_val("busy_len", 32'(cnt), 32'(pe ? 11 : 10));
   endtask

   initial begin
      int found;
      bus.p_data = 8'h00;
      bus.data_valid = 1'b0;
      bus.par_en = 1'b0;
      bus.par_typ = 1'b0;
      #12 rst_n = 1'b1;

      repeat (5) begin
         @(negedge clk);
         check_val("ser_idle", 32'(bus.ser_data), 32'd0);
      end

      send(8'hA5, 1'b1, 1'b0, 0);
      check_val("par_a5_even", 32'(bus.par_bit), 32'd0);
      send(8'h01, 1'b1, 1'b1, 0);
      check_val("par_01_odd", 32'(bus.par_bit), 32'd0);
      send(8'h01, 1'b1, 1'b0, 0);
      check_val("par_01_even", 32'(bus.par_bit), 32'd1);
      send(8'hFF, 1'b0, 1'b0, 0);
      send(8'h81, 1'b1, 1'b0, 5);

      // data_valid during STOP
      @(negedge clk);
      bus.p_data = 8'hC3;
      bus.par_en = 1'b1;
      bus.par_typ = 1'b0;
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.data_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         if (bus.busy && bus.mux_sel == 2'b01) found = 1;
         else @(negedge clk);
      end
      check_val("reach_stop", 32'(found), 32'd1);
      bus.p_data = 8'h96;
      bus.par_en = 1'b0;
      bus.par_typ = 1'b1;
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.data_valid = 1'b0;
`ifdef UART_TX_BACK2BACK_EN
      check_val("b2b_start", 32'(bus.mux_sel), 32'(2'b00));
      check_val("b2b_busy", 32'(bus.busy), 32'd1);
`else
      check_val("stop_ignore_sel", 32'(bus.mux_sel), 32'(2'b01));
      check_val("stop_ignore_busy", 32'(bus.busy), 32'd0);
`endif
      repeat (14) @(negedge clk);

      // Asynchronous reset during DATA bit 4
      @(negedge clk);
      bus.p_data = 8'hE7;
      bus.par_en = 1'b1;
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.data_valid = 1'b0;
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_val("rst_sel", 32'(bus.mux_sel), 32'(2'b01));
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_ser", 32'(bus.ser_data), 32'd0);
      check_val("rst_par", 32'(bus.par_bit), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      send(8'h5A, 1'b1, 1'b1, 0);
      check_val("par_5a_odd", 32'(bus.par_bit), 32'd1);

      for (int k = 0; k < 40; k++) begin
         logic pe;
         pe = 1'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(8'($urandom), pe, 1'($urandom),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 8)) : 0);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Control and datapath stage of the UART transmitter, directly upstream of the TX output mux. It accepts a parallel byte and sequences start, data, optional parity and stop phases. It produces the mux select, the serial data bit and the parity bit that the output mux registers onto the TX line. One bit period equals one clk cycle; the clk is the baud-rate clock from the prescaler.

Parameters:
DATA_WIDTH, 8, width of the parallel data word; the bit counter is sized $clog2(DATA_WIDTH).

Ports:
clk       input   1            baud-rate clock
rst_n     input   1            asynchronous active-low reset
p_data    input   DATA_WIDTH   parallel byte to send
data_valid input  1            one-cycle request; p_data is valid while high
par_en    input   1            1 = insert parity bit
par_typ   input   1            0 = even, 1 = odd
mux_sel   output  2            00 start (0), 01 stop/idle (1), 10 serial data, 11 parity
ser_data  output  1            current data bit, LSB first
par_bit   output  1            computed parity bit
busy      output  1            frame in progress

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, mux_sel = 01, busy = 0, ser_data = 0, par_bit = 0.
  - Shift register and bit counter are cleared.
  - Reset mid-frame aborts immediately. The line returns to idle-high via mux_sel = 01.
- States: IDLE, START, DATA, PARITY, STOP.
- Outputs are decoded from the registered state:
  - mux_sel: IDLE = 01, START = 00, DATA = 10, PARITY = 11, STOP = 01.
  - busy = (state != IDLE).
- IDLE:
  - If data_valid = 1, latch p_data into the shift register and latch par_en.
  - Compute par_bit: even = ^p_data, odd = ~^p_data.
  - Go to START. Otherwise stay in IDLE.
- START: one cycle, then DATA with bit counter = 0 and ser_data = p_data[0].
- DATA:
  - One cycle per bit; shift right on each clk.
  - After the cycle with counter = DATA_WIDTH-1, go to PARITY if latched par_en = 1, else STOP.
- PARITY: one cycle, then STOP.
- STOP: one cycle, then IDLE (see optional feature).
- Latency: data_valid sampled at edge N gives START for cycle N+1.
  - DATA occupies N+2 .. N+1+DATA_WIDTH.
  - PARITY occupies N+10, then STOP N+11 (DATA_WIDTH = 8).
  - With no parity, STOP occupies N+10.
  - The downstream mux adds one more register stage on the TX line.
- data_valid while busy is ignored. No queuing and no error flag.
- Latched values (p_data, par_en, par_bit) are stable for the whole frame. Input changes mid-frame have no effect.
- par_bit holds its value until the next acceptance.

Optional Feature:
UART_TX_BACK2BACK_EN
- Defined:
  - data_valid during the STOP cycle is accepted: data and parity are latched and the next state is START (no IDLE cycle).
  - busy stays high across frames.
- Undefined: STOP always goes to IDLE, and data_valid in STOP is ignored.

Decomposition:
- Package uart_tx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP).
  - mux_sel constants SEL_START = 2'b00, SEL_STOP = 2'b01, SEL_DATA = 2'b10, SEL_PAR = 2'b11.
  - The output mux uses the same constants.
- Sub-module uart_tx_serializer:
  - Contains the shift register and bit counter.
  - Inputs: load, shift_en, p_data.
  - Outputs: ser_data, ser_done.
  - The FSM and parity logic stay in uart_tx_ctrl.

Test Plan:
- Reset then idle 5 cycles -> mux_sel = 01, busy = 0, ser_data = 0, par_bit = 0 throughout.
- p_data = 0xA5, par_en = 1, par_typ = 0, one-cycle data_valid -> mux_sel 00, 10 x8, 11, 01.
  - ser_data over DATA = 1,0,1,0,0,1,0,1.
  - par_bit = 0.
  - busy high for 11 cycles.
- p_data = 0x01, par_en = 1, par_typ = 1 -> par_bit = 0. Same byte with par_typ = 0 -> par_bit = 1.
- p_data = 0xFF, par_en = 0 -> no 11 phase, STOP in cycle N+10, busy high for 10 cycles.
- data_valid pulsed mid-DATA with p_data = 0x3C -> ignored; the frame is unchanged, and IDLE follows STOP.
  - With UART_TX_BACK2BACK_EN, data_valid in STOP -> START on the next cycle and the second frame is sent intact.
- rst_n asserted during DATA bit 4 -> mux_sel = 01 and busy = 0 immediately (asynchronous).
  - After release, a new frame with 0x5A transmits correctly.
